img_loader: RTL and testbench

//  Upstream of alu_algoritmos. Takes 32-bit words from the HPS bridge over a valid/ready handshake.

---
 rtl/img_loader_pkg.sv | 17 +
 rtl/img_loader_if.sv | 15 +
 rtl/img_loader.sv | 86 ++++++++
 tb/tb_img_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_loader_pkg.sv
// img_loader_pkg: image geometry and loader state encoding shared by the loader slice.
package img_loader_pkg;
    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int IMG_WORDS  = IMG_PIXELS / 4;
    localparam int ADDR_W     = 15;
    localparam int PIX_W      = 8;
    localparam int CNT_W      = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/img_loader_if.sv
// img_loader_if: HPS word handshake plus source RAM write port of the image loader.
interface img_loader_if #(
    parameter int ADDR_W = img_loader_pkg::ADDR_W,
    parameter int PIX_W  = img_loader_pkg::PIX_W
);
    logic               wr_valid;
    logic [4*PIX_W-1:0] wr_data;
    logic               wr_ready;
    logic [ADDR_W-1:0]  ram_addr_out;
    logic [PIX_W-1:0]   ram_data_out;
    logic               ram_wren_out;

    modport master (output wr_valid, wr_data, input wr_ready, ram_addr_out, ram_data_out, ram_wren_out);
    modport slave  (input wr_valid, wr_data, output wr_ready, ram_addr_out, ram_data_out, ram_wren_out);
endinterface

// File: rtl/img_loader.sv
// img_loader: unpacks HPS 32-bit words into four pixel writes to the source image RAM.
module img_loader #(
    parameter int IMG_W  = img_loader_pkg::IMG_W,
    parameter int IMG_H  = img_loader_pkg::IMG_H,
    parameter int ADDR_W = img_loader_pkg::ADDR_W,
    parameter int PIX_W  = img_loader_pkg::PIX_W
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             cmd_start,
    input  logic                             cmd_abort,
    img_loader_if.slave                      bus,
    output logic                             alu_start_out,
    output logic                             busy_out,
    output logic                             done_out,
    output logic [img_loader_pkg::CNT_W-1:0] word_cnt_out
);
    import img_loader_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(IMG_W * IMG_H / 4);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [1:0]         byte_sel_q, byte_sel_d;
    logic [4*PIX_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start, take, last_byte;

    // abort outranks a simultaneous start
    assign start     = cmd_start & ~cmd_abort;
    assign take      = state_q == RECV && bus.wr_valid && !cmd_abort;
    assign last_byte = byte_sel_q == 2'd3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            byte_sel_q <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            byte_sel_q <= byte_sel_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RECV : IDLE;
            RECV:    state_d = cmd_abort ? IDLE : bus.wr_valid ? WRITE : RECV;
            WRITE:   state_d = cmd_abort ? IDLE : !last_byte ? WRITE : addr_q == LAST_ADDR ? DONE : RECV;
            default: state_d = IDLE;
        endcase
        // address holds at the last pixel so it never leaves the image
        addr_d     = state_q == IDLE && start ? '0 :
                     state_q == WRITE && addr_q != LAST_ADDR ? addr_q + 1'b1 : addr_q;
        byte_sel_d = take ? 2'd0 : state_q == WRITE ? byte_sel_q + 2'd1 : byte_sel_q;
        word_d     = take ? bus.wr_data : word_q;
        word_cnt_d = state_q == IDLE && start ? '0 :
                     take && word_cnt_q != MAX_WORDS ? word_cnt_q + 1'b1 : word_cnt_q;
        busy_d     = state_q == IDLE ? start : state_q == DONE || cmd_abort ? 1'b0 : busy_q;
        done_d     = state_q == IDLE && start ? 1'b0 : state_q == DONE ? 1'b1 : done_q;
    end

    always_comb begin
        bus.wr_ready     = state_q == RECV;
        bus.ram_wren_out = state_q == WRITE;
        bus.ram_addr_out = addr_q;
        bus.ram_data_out = word_q[PIX_W*byte_sel_q +: PIX_W];
        alu_start_out    = state_q == DONE;
        busy_out         = busy_q;
        done_out         = done_q;
        word_cnt_out     = word_cnt_q;
    end
endmodule

// File: tb/tb_img_loader.sv
// tb_img_loader: randomized loads of img_loader checked against a write-order and RAM scoreboard.
module tb_img_loader;
    import img_loader_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cmd_start = 1'b0;
    logic             cmd_abort = 1'b0;
    logic             alu_start_out, busy_out, done_out;
    logic [CNT_W-1:0] word_cnt_out;

    img_loader_if bus();

    img_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_start    (cmd_start),
        .cmd_abort    (cmd_abort),
        .bus          (bus),
        .alu_start_out(alu_start_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .word_cnt_out (word_cnt_out)
    );

    always #5 clk = ~clk;

    typedef struct {int a; int d;} wr_t;
    wr_t        exp_q[$];
    logic [7:0] ref_mem [0:32767];
    logic [7:0] obs_mem [0:32767];
    int         n_checks = 0, n_pass = 0;
    int         n_acc = 0, n_writes = 0, n_alu = 0, last_addr = -1;
    bit         m_busy = 1'b0, m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // every accepted word expands into four pixel writes at 4*n .. 4*n+3, byte0 first
    always @(negedge clk) begin : mon
        wr_t e;
        if (bus.ram_wren_out) n_writes++;
        if (alu_start_out) n_alu++;
        if (!reset_n) exp_q.delete();
        else begin
            if (bus.ram_wren_out) begin
                check("wr_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.ram_addr_out), e.a);
                    check("wr_data", 32'(bus.ram_data_out), e.d);
                end
                check("ready_in_write", 32'(bus.wr_ready), 0);
                obs_mem[bus.ram_addr_out] = bus.ram_data_out;
                last_addr = int'(bus.ram_addr_out);
            end
            if (cmd_abort) exp_q.delete();
            else if (bus.wr_valid && bus.wr_ready) begin
                for (int b = 0; b < 4; b++) begin
                    e.a = 4 * n_acc + b;
                    e.d = int'(bus.wr_data[8*b +: 8]);
                    ref_mem[e.a[14:0]] = bus.wr_data[8*b +: 8];
                    exp_q.push_back(e);
                end
                n_acc++;
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        bit ok = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = w;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = bus.wr_ready;
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        if (!ok) begin
            check("hs_timeout", 32'(ok), 1);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "handshake never completed");
        end
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        if (!m_busy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            n_acc  = 0;
        end
    endtask

    task automatic do_abort();
        cmd_abort = 1'b1;
        @(posedge clk);
        #1;
        cmd_abort = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_busy"}, 32'(busy_out), 32'(m_busy));
        check({tag, "_done"}, 32'(done_out), 32'(m_done));
        check({tag, "_cnt"}, 32'(word_cnt_out), n_acc);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.wr_ready), 0);
        check({tag, "_wren"}, 32'(bus.ram_wren_out), 0);
        check({tag, "_addr"}, 32'(bus.ram_addr_out), 0);
        check({tag, "_data"}, 32'(bus.ram_data_out), 0);
        check({tag, "_alu"}, 32'(alu_start_out), 0);
        check({tag, "_busy"}, 32'(busy_out), 0);
        check({tag, "_done"}, 32'(done_out), 0);
        check({tag, "_cnt"}, 32'(word_cnt_out), 0);
    endtask

    task automatic cmp_mem(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) check("mem", 32'(obs_mem[a]), 32'(ref_mem[a]));
    endtask

    initial begin
        logic [31:0] w;
        int a0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = $urandom;
        // reset with a word already offered
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_ready", 32'(bus.wr_ready), 0);
        check("idle_no_writes", n_writes, 0);
        check_status("idle");
        bus.wr_valid = 1'b0;

        // single word unpack order and timing
        pulse_start();
        w = 32'h44332211;
        send_word(w);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("w1_wren", 32'(bus.ram_wren_out), 1);
            check("w1_addr", 32'(bus.ram_addr_out), b);
            check("w1_data", 32'(bus.ram_data_out), 32'((w >> (8 * b)) & 32'hff));
            check("w1_ready", 32'(bus.wr_ready), 0);
        end
        @(negedge clk);
        check("w1_back_ready", 32'(bus.wr_ready), 1);
        check("w1_wren_off", 32'(bus.ram_wren_out), 0);
        check_status("w1");
        @(posedge clk);
        #1;
        do_abort();
        check_status("w1_abort");

        // abort in the middle of word 100
        pulse_start();
        for (int i = 0; i < 100; i++) send_word($urandom);
        a0 = n_alu;
        send_word($urandom);
        @(posedge clk);
        #1;
        check("ab_wren_before", 32'(bus.ram_wren_out), 1);
        do_abort();
        check("ab_wren_dropped", 32'(bus.ram_wren_out), 0);
        check("ab_no_alu", n_alu - a0, 0);
        check_status("ab");
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        @(posedge clk);
        #1;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        check("ab_start_lost", 32'(busy_out), 0);
        check("ab_start_ready", 32'(bus.wr_ready), 0);
        pulse_start();
        send_word($urandom);
        @(negedge clk);
        check("restart_addr", 32'(bus.ram_addr_out), 0);
        check("restart_wren", 32'(bus.ram_wren_out), 1);
        repeat (5) @(posedge clk);
        #1;
        do_abort();

        // random gaps and ignored start pulses during a load
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            send_word($urandom);
            if ($urandom_range(0, 3) == 0) pulse_start();
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        check_status("gap");
        check("gap_words", n_acc, 400);
        check("gap_pending", exp_q.size(), 0);
        do_abort();
        cmp_mem(0, 1599);

        // asynchronous reset in the middle of a load
        pulse_start();
        for (int i = 0; i < 2000; i++) send_word($urandom);
        a0 = n_alu;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("async_rst");
        m_busy = 1'b0;
        m_done = 1'b0;
        n_acc  = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("rst_no_alu", n_alu - a0, 0);

        // full image with an address pattern
        pulse_start();
        for (int i = 0; i < IMG_WORDS; i++) begin
            w = {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
            send_word(w);
        end
        for (int t = 0; t < 20 && n_alu == a0; t++) @(negedge clk);
        check("full_alu_seen", n_alu - a0, 1);
        m_busy = 1'b0;
        m_done = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("full_alu_once", n_alu - a0, 1);
        check_status("full");
        check("full_words", n_acc, IMG_WORDS);
        check("full_last_addr", last_addr, IMG_PIXELS - 1);
        check("full_pending", exp_q.size(), 0);
        check("full_idle_ready", 32'(bus.wr_ready), 0);
        cmp_mem(0, IMG_PIXELS - 1);

        // a new start clears the sticky done flag
        pulse_start();
        check_status("restart");
        do_abort();
        check_status("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
